mem_stage: RTL and testbench

- Memory-access stage that sits directly downstream of the execute ALU.
- Consumes the ALU result (either an effective address or a pass-through value) plus the store data and control bits.
- Performs load/store transactions on a req/ack data-memory port, with byte/half/word lane alignment and sign/zero extension.
- Presents a registered result to writeback and back-pressures execute with a ready signal while a transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_lane_align.sv | 50 +++++
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: size encodings, lane
// geometry, FSM state type and lane/alignment helper functions.
package mem_stage_pkg;

  localparam int MEM_DWIDTH = 32;
  localparam int MEM_AWIDTH = 32;
  localparam int MEM_LANES  = 4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  // True when the access size is legal and the low address bits fit it.
  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = (lo[0] == 1'b0);
      SIZE_W:  ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian byte enables for an access of the given size/offset.
  function automatic logic [MEM_LANES-1:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [MEM_LANES-1:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << lo;
      SIZE_H:  be = 4'b0011 << {lo[1], 1'b0};
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational lane steering. With LOAD=0 it replicates store data across
// the byte lanes; with LOAD=1 it extracts a lane from read data and extends it.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [MEM_DWIDTH-1:0] data_in,
  input  logic [1:0]            addr_lo,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [MEM_DWIDTH-1:0] data_out
);

  logic [MEM_DWIDTH-1:0] store_val;
  logic [MEM_DWIDTH-1:0] shifted;
  logic [MEM_DWIDTH-1:0] load_val;

  // Store path: replicate the low byte/half so any lane selected by be sees it.
  always_comb begin
    store_val = data_in;
    case (size)
      SIZE_B:  store_val = {4{data_in[7:0]}};
      SIZE_H:  store_val = {2{data_in[15:0]}};
      SIZE_W:  store_val = data_in;
      default: store_val = data_in;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    shifted  = data_in >> {addr_lo, 3'b000};
    load_val = shifted;
    case (size)
      SIZE_B: begin
        if (is_unsigned) load_val = {24'h000000, shifted[7:0]};
        else             load_val = {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        if (is_unsigned) load_val = {16'h0000, shifted[15:0]};
        else             load_val = {{16{shifted[15]}}, shifted[15:0]};
      end
      SIZE_W:  load_val = shifted;
      default: load_val = shifted;
    endcase
  end

  assign data_out = LOAD ? load_val : store_val;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues aligned load/store requests on a req/ack port,
// aligns and extends data, and presents a one-cycle registered writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              m_i_clk,
  input  logic              m_i_rst,
  input  logic              m_i_valid,
  output logic              m_o_ready,
  input  logic              m_i_flush,
  input  logic [DWIDTH-1:0] m_i_alu_value,
  input  logic [DWIDTH-1:0] m_i_data_rt,
  input  logic [RWIDTH-1:0] m_i_rd,
  input  logic              m_i_reg_write,
  input  logic              m_i_mem_read,
  input  logic              m_i_mem_write,
  input  logic [1:0]        m_i_size,
  input  logic              m_i_unsigned,
  output logic              m_o_req,
  output logic              m_o_we,
  output logic [AWIDTH-1:0] m_o_addr,
  output logic [DWIDTH-1:0] m_o_wdata,
  output logic [3:0]        m_o_be,
  input  logic              m_i_ack,
  input  logic [DWIDTH-1:0] m_i_rdata,
  output logic              m_o_valid,
  output logic [DWIDTH-1:0] m_o_value,
  output logic [RWIDTH-1:0] m_o_rd,
  output logic              m_o_reg_write,
  output logic              m_o_misalign
);

  mem_state_t        state;
  logic [1:0]        addr_lo;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [RWIDTH-1:0] rd_q;
  logic              reg_write_q;

  logic              accept;
  logic              is_mem;
  logic              aligned;
  logic [DWIDTH-1:0] store_lanes;
  logic [DWIDTH-1:0] load_value;

  assign m_o_ready = (state == ST_IDLE);
  assign accept    = (state == ST_IDLE) && m_i_valid && !m_i_flush;
  assign is_mem    = m_i_mem_read || m_i_mem_write;
  assign aligned   = size_aligned(m_i_size, m_i_alu_value[1:0]);

  mem_lane_align #(.LOAD(1'b0)) u_store_align (
    .data_in     (m_i_data_rt),
    .addr_lo     (m_i_alu_value[1:0]),
    .size        (m_i_size),
    .is_unsigned (m_i_unsigned),
    .data_out    (store_lanes)
  );

  mem_lane_align #(.LOAD(1'b1)) u_load_align (
    .data_in     (m_i_rdata),
    .addr_lo     (addr_lo),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data_out    (load_value)
  );

  // Stage FSM: accepts instructions in IDLE, holds the request in ACCESS until ack.
  always_ff @(posedge m_i_clk or posedge m_i_rst) begin
    if (m_i_rst) begin
      state         <= ST_IDLE;
      addr_lo       <= 2'b00;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      m_o_req       <= 1'b0;
      m_o_we        <= 1'b0;
      m_o_addr      <= '0;
      m_o_wdata     <= '0;
      m_o_be        <= 4'b0000;
      m_o_valid     <= 1'b0;
      m_o_value     <= '0;
      m_o_rd        <= '0;
      m_o_reg_write <= 1'b0;
      m_o_misalign  <= 1'b0;
    end else begin
      // Writeback outputs are pulses; they fall back to zero unless set below.
      m_o_valid     <= 1'b0;
      m_o_value     <= '0;
      m_o_rd        <= '0;
      m_o_reg_write <= 1'b0;
      m_o_misalign  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              m_o_valid     <= 1'b1;
              m_o_value     <= m_i_alu_value;
              m_o_rd        <= m_i_rd;
              m_o_reg_write <= m_i_reg_write;
            end else if (!aligned) begin
              m_o_misalign <= 1'b1;
            end else begin
              state       <= ST_ACCESS;
              addr_lo     <= m_i_alu_value[1:0];
              size_q      <= m_i_size;
              unsigned_q  <= m_i_unsigned;
              rd_q        <= m_i_rd;
              reg_write_q <= m_i_reg_write;
              m_o_req     <= 1'b1;
              m_o_we      <= m_i_mem_write;
              m_o_addr    <= {m_i_alu_value[AWIDTH-1:2], 2'b00};
              m_o_wdata   <= store_lanes;
              m_o_be      <= lane_be(m_i_size, m_i_alu_value[1:0]);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (m_i_ack) begin
            state     <= ST_IDLE;
            m_o_req   <= 1'b0;
            m_o_we    <= 1'b0;
            m_o_addr  <= '0;
            m_o_wdata <= '0;
            m_o_be    <= 4'b0000;
            m_o_valid <= 1'b1;
            m_o_rd    <= rd_q;
            if (m_o_we) begin
              m_o_reg_write <= 1'b0;
            end else begin
              m_o_value     <= load_value;
              m_o_reg_write <= reg_write_q;
            end
          end else begin
            state <= ST_ACCESS;
          end
        end
        default: begin
          state   <= ST_IDLE;
          m_o_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        flush;
  logic [31:0] alu_value;
  logic [31:0] data_rt;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        is_unsigned;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        o_valid;
  logic [31:0] o_value;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic        o_misalign;

  typedef struct {
    logic        valid;
    logic        misalign;
    logic        reg_write;
    logic [31:0] value;
    logic [4:0]  rd;
  } wb_t;

  wb_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  mem_stage dut (
    .m_i_clk       (clk),
    .m_i_rst       (rst),
    .m_i_valid     (valid),
    .m_o_ready     (ready),
    .m_i_flush     (flush),
    .m_i_alu_value (alu_value),
    .m_i_data_rt   (data_rt),
    .m_i_rd        (rd),
    .m_i_reg_write (reg_write),
    .m_i_mem_read  (mem_read),
    .m_i_mem_write (mem_write),
    .m_i_size      (size),
    .m_i_unsigned  (is_unsigned),
    .m_o_req       (req),
    .m_o_we        (we),
    .m_o_addr      (addr),
    .m_o_wdata     (wdata),
    .m_o_be        (be),
    .m_i_ack       (ack),
    .m_i_rdata     (rdata),
    .m_o_valid     (o_valid),
    .m_o_value     (o_value),
    .m_o_rd        (o_rd),
    .m_o_reg_write (o_reg_write),
    .m_o_misalign  (o_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic v, input logic mis, input logic rw, input logic [31:0] val, input logic [4:0] r);
    wb_t e;
    e.valid = v; e.misalign = mis; e.reg_write = rw; e.value = val; e.rd = r;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every writeback/misalign pulse must match the oldest expectation.
  task automatic monitor();
    wb_t e;
    if (o_valid === 1'b1 || o_misalign === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, o_valid, o_misalign}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_valid", {31'd0, o_valid}, {31'd0, e.valid});
        chk("wb_misalign", {31'd0, o_misalign}, {31'd0, e.misalign});
        chk("wb_reg_write", {31'd0, o_reg_write}, {31'd0, e.reg_write});
        if (e.valid) chk("wb_rd", {27'd0, o_rd}, {27'd0, e.rd});
        if (e.reg_write) chk("wb_value", o_value, e.value);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic idle_inputs();
    valid = 1'b0; flush = 1'b0; alu_value = 32'd0; data_rt = 32'd0; rd = 5'd0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; is_unsigned = 1'b0;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] rt, input logic [4:0] r, input logic rw,
                    input logic rdn, input logic wrn, input logic [1:0] sz, input logic uns);
    valid = 1'b1; flush = 1'b0; alu_value = a; data_rt = rt; rd = r; reg_write = rw;
    mem_read = rdn; mem_write = wrn; size = sz; is_unsigned = uns;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rdata = 32'd0;
    idle_inputs();
    #12;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);

    // Non-memory pass-through, back-to-back.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      op(32'h0000_1234, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
      push(1'b1, 1'b0, 1'b1, 32'h0000_1234, 5'd7);
      cyc();
      chk("pass_valid", {31'd0, o_valid}, 32'd1);
      chk("pass_ready", {31'd0, ready}, 32'd1);
    end
    idle_inputs();
    cyc();
    chk("pass_idle_valid", {31'd0, o_valid}, 32'd0);

    // Signed byte load at 0x103, ack two cycles after req.
    op(32'h0000_0103, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    cyc();
    idle_inputs();
    chk("lb_req", {31'd0, req}, 32'd1);
    chk("lb_we", {31'd0, we}, 32'd0);
    chk("lb_addr", addr, 32'h0000_0100);
    chk("lb_be", {28'd0, be}, 32'h8);
    chk("lb_ready", {31'd0, ready}, 32'd0);
    cyc();
    cyc();
    chk("lb_req_hold", {31'd0, req}, 32'd1);
    chk("lb_ready_hold", {31'd0, ready}, 32'd0);
    ack = 1'b1; rdata = 32'h80FF_0000;
    push(1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 5'd3);
    cyc();
    ack = 1'b0; rdata = 32'd0;
    chk("lb_done_valid", {31'd0, o_valid}, 32'd1);
    chk("lb_done_ready", {31'd0, ready}, 32'd1);
    chk("lb_done_req", {31'd0, req}, 32'd0);

    // Unsigned half load at 0x102 with minimum latency.
    op(32'h0000_0102, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    cyc();
    idle_inputs();
    chk("lhu_be", {28'd0, be}, 32'hC);
    chk("lhu_addr", addr, 32'h0000_0100);
    ack = 1'b1; rdata = 32'h8001_0000;
    push(1'b1, 1'b0, 1'b1, 32'h0000_8001, 5'd4);
    cyc();
    ack = 1'b0;
    chk("lhu_valid", {31'd0, o_valid}, 32'd1);

    // Byte store at 0x201.
    op(32'h0000_0201, 32'hAABB_CCDD, 5'd5, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    cyc();
    idle_inputs();
    chk("sb_we", {31'd0, we}, 32'd1);
    chk("sb_be", {28'd0, be}, 32'h2);
    chk("sb_wdata", wdata, 32'hDDDD_DDDD);
    chk("sb_addr", addr, 32'h0000_0200);
    ack = 1'b1;
    push(1'b1, 1'b0, 1'b0, 32'd0, 5'd5);
    cyc();
    ack = 1'b0;

    // Half store at 0x302.
    op(32'h0000_0302, 32'h1111_BEEF, 5'd6, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    cyc();
    idle_inputs();
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wdata", wdata, 32'hBEEF_BEEF);
    ack = 1'b1;
    push(1'b1, 1'b0, 1'b0, 32'd0, 5'd6);
    cyc();
    ack = 1'b0;

    // Misaligned word load, then illegal size.
    op(32'h0000_0102, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    push(1'b0, 1'b1, 1'b0, 32'd0, 5'd0);
    cyc();
    idle_inputs();
    chk("mis_req", {31'd0, req}, 32'd0);
    chk("mis_pulse", {31'd0, o_misalign}, 32'd1);
    chk("mis_valid", {31'd0, o_valid}, 32'd0);
    cyc();
    chk("mis_clear", {31'd0, o_misalign}, 32'd0);
    op(32'h0000_0100, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    push(1'b0, 1'b1, 1'b0, 32'd0, 5'd0);
    cyc();
    idle_inputs();
    chk("ill_req", {31'd0, req}, 32'd0);
    chk("ill_pulse", {31'd0, o_misalign}, 32'd1);
    cyc();

    // Flush during ACCESS is ignored; the transaction completes.
    op(32'h0000_0104, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    cyc();
    idle_inputs();
    flush = 1'b1;
    cyc();
    chk("flush_acc_req", {31'd0, req}, 32'd1);
    flush = 1'b0;
    ack = 1'b1; rdata = 32'h1234_5678;
    push(1'b1, 1'b0, 1'b1, 32'h1234_5678, 5'd9);
    cyc();
    ack = 1'b0;
    chk("flush_acc_valid", {31'd0, o_valid}, 32'd1);

    // Flush in IDLE with valid: nothing comes out.
    op(32'h0000_5555, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    flush = 1'b1;
    cyc();
    idle_inputs();
    chk("flush_idle_valid", {31'd0, o_valid}, 32'd0);

    // Ack while idle is ignored.
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    cyc();
    ack = 1'b0;
    chk("stray_ack_valid", {31'd0, o_valid}, 32'd0);

    // Reset asserted in ACCESS drops req immediately.
    op(32'h0000_0108, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    cyc();
    idle_inputs();
    chk("rst_acc_req_before", {31'd0, req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_acc_req", {31'd0, req}, 32'd0);
    #3;
    rst = 1'b0;
    cyc();
    chk("rst_acc_ready", {31'd0, ready}, 32'd1);
    chk("rst_acc_req_after", {31'd0, req}, 32'd0);
    chk("rst_acc_valid", {31'd0, o_valid}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
